fft_window: RTL and testbench

Streaming window stage between the FFT input buffer and the FFT core. Takes the contiguous NSamples-long sample bursts from the input buffer and multiplies each sample by a periodic Hann coefficient indexed by its position in the frame. Rounds the result and emits a framed stream (valid/sop/eop) to the FFT sink. Detects broken bursts and resynchronises the frame index.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_window_rom.sv | 34 +++
 rtl/fft_window.sv | 95 +++++++++
 tb/tb_fft_window.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT window stage and its sink.
package fft_pkg;

    localparam int W              = 16;
    localparam int NSAMPLES       = 1024;
    localparam int CW             = 16;
    localparam int IW             = $clog2(NSAMPLES);
    localparam int WINDOW_LATENCY = 3;

    localparam string HANN_FILE = "fft_window_hann.hex";

    typedef logic signed [W-1:0]  sample_t;
    typedef logic [CW-1:0]        coef_t;
    typedef logic [IW-1:0]        idx_t;
    typedef logic signed [W+CW:0] prod_t;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } flags_t;

    // Round half toward +inf, drop CW fraction bits, clamp to sample range.
    function automatic sample_t round_sat(input prod_t p);
        prod_t             s;
        logic signed [W:0] r;
        s = p + prod_t'(1 << (CW - 1));
        r = s[W+CW:CW];
        if (r[W] != r[W-1]) begin
            return r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return r[W-1:0];
    endfunction

endpackage

// File: rtl/fft_window_rom.sv
// Hann coefficient ROM, synchronous read; built only with FFT_WINDOW_EN.
`ifdef FFT_WINDOW_EN
module window_rom
    import fft_pkg::*;
(
    input  logic  clk,
    input  idx_t  addr_i,
    output coef_t data_o
);

    coef_t rom [NSAMPLES];
    coef_t data_q;

    function automatic coef_t hann_c(input int n);
        real cr;
        cr = (2.0 ** CW - 1.0) * 0.5 *
             (1.0 - $cos(2.0 * 3.141592653589793 * n / NSAMPLES));
        return coef_t'(longint'($floor(cr + 0.5)));
    endfunction

    initial begin
        for (int i = 0; i < NSAMPLES; i++) begin
            rom[i] = hann_c(i);
        end
    end

    always_ff @(posedge clk) begin
        data_q <= rom[addr_i];
    end

    assign data_o = data_q;

endmodule
`endif

// File: rtl/fft_window.sv
// Streaming Hann window stage: 3-cycle pipeline with frame resync.
// FFT_WINDOW_EN selects Hann multiply; otherwise a rectangular window.
module fft_window
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    in_data,
    input  logic            in_valid,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic            out_sop,
    output logic            out_eop,
    output logic            frame_err
);

    idx_t    idx_q, idx_d;
    logic    err_q, err_d;
    flags_t  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    sample_t s1_data_q, s1_data_d;
    sample_t s3_data_q, s3_data_d;

`ifdef FFT_WINDOW_EN
    coef_t coef;
    prod_t s2_data_q, s2_data_d;

    window_rom u_rom (
        .clk    (clk),
        .addr_i (idx_q),
        .data_o (coef)
    );
`else
    sample_t s2_data_q, s2_data_d;
`endif

    always_comb begin
        idx_d = idx_q;
        err_d = 1'b0;
        if (in_valid) begin
            idx_d = idx_q + 1'b1;
        end else if (idx_q != '0) begin
            // Broken burst: restart the frame and flag the partial one.
            idx_d = '0;
            err_d = 1'b1;
        end

        s1_d.valid = in_valid;
        s1_d.sop   = in_valid && (idx_q == '0);
        s1_d.eop   = in_valid && (idx_q == idx_t'(NSAMPLES - 1));
        s1_data_d  = in_data;

        s2_d = s1_q;
`ifdef FFT_WINDOW_EN
        s2_data_d = prod_t'(s1_data_q) * prod_t'({1'b0, coef});
`else
        s2_data_d = s1_data_q;
`endif

        s3_d = s2_q;
`ifdef FFT_WINDOW_EN
        s3_data_d = round_sat(s2_data_q);
`else
        s3_data_d = s2_data_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q     <= '0;
            err_q     <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            s3_data_q <= '0;
        end else begin
            idx_q     <= idx_d;
            err_q     <= err_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            s3_data_q <= s3_data_d;
        end
    end

    assign out_data  = s3_data_q;
    assign out_valid = s3_q.valid;
    assign out_sop   = s3_q.sop;
    assign out_eop   = s3_q.eop;
    assign frame_err = err_q;

endmodule

// File: tb/tb_fft_window.sv
// Scoreboard bench for fft_window: driver predicts, monitor compares.
module tb_fft_window;
    import fft_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    sample_t in_data;
    logic    in_valid;
    sample_t out_data;
    logic    out_valid, out_sop, out_eop, frame_err;

    always #5 clk = ~clk;

    fft_window dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .frame_err (frame_err)
    );

    typedef struct {
        sample_t d;
        logic    sop;
        logic    eop;
        int      cyc;
    } exp_t;

    exp_t sq[$];
    int   eq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   m_idx = 0;
    bit   rst_seen = 1'b0;
    bit   mon_en = 1'b0;
    exp_t mon_e;
    int   mon_c;

    sample_t vecs [8] = '{16'sh7FFF, -16'sh8000, 16'sh0001, -16'sh0001,
                          16'sh0000, 16'sh1234, -16'sh4321, 16'sh4000};

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

`ifdef FFT_WINDOW_EN
    function automatic sample_t hann(input sample_t d, input int n);
        real    cr;
        longint c, p, r;
        cr = 65535.0 * 0.5 *
             (1.0 - $cos(2.0 * 3.141592653589793 * n / NSAMPLES));
        c = longint'($floor(cr + 0.5));
        p = longint'(d) * c;
        r = (p + 32768) >>> 16;
        if (r > 32767) return 16'sh7FFF;
        if (r < -32768) return -16'sh8000;
        return sample_t'(r);
    endfunction
`endif

    always @(posedge clk) begin
        cyc++;
        rst_seen = !reset;
        mon_en = 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                chk({out_data, out_valid, out_sop, out_eop, frame_err} == '0,
                    "reset_zero",
                    longint'({out_data, out_valid, out_sop, out_eop, frame_err}),
                    0);
            end else begin
                if (out_valid) begin
                    if (sq.size() == 0) begin
                        chk(1'b0, "unexpected_valid", longint'(out_data), 0);
                    end else begin
                        mon_e = sq.pop_front();
                        chk(mon_e.cyc == cyc, "latency", cyc, mon_e.cyc);
                        chk(out_data == mon_e.d, "data",
                            longint'(out_data), longint'(mon_e.d));
                        chk({out_sop, out_eop} == {mon_e.sop, mon_e.eop},
                            "sop_eop", longint'({out_sop, out_eop}),
                            longint'({mon_e.sop, mon_e.eop}));
                    end
                end else begin
                    chk(!out_sop && !out_eop, "flags_idle",
                        longint'({out_sop, out_eop}), 0);
                    if (sq.size() > 0 && sq[0].cyc <= cyc) begin
                        mon_e = sq.pop_front();
                        chk(1'b0, "missing_output", 0, mon_e.cyc);
                    end
                end
                if (frame_err) begin
                    if (eq.size() == 0) begin
                        chk(1'b0, "spurious_frame_err", 1, 0);
                    end else begin
                        mon_c = eq.pop_front();
                        chk(mon_c == cyc, "frame_err_cycle", cyc, mon_c);
                    end
                end else if (eq.size() > 0 && eq[0] <= cyc) begin
                    mon_c = eq.pop_front();
                    chk(1'b0, "missing_frame_err", 0, mon_c);
                end
            end
        end
    end

    task automatic step(input bit rst_n, input bit v, input sample_t d);
        sample_t ed;
        @(negedge clk);
        #1;
        reset    = rst_n;
        in_valid = v;
        in_data  = d;
        if (!rst_n) begin
            sq.delete();
            eq.delete();
            m_idx = 0;
        end else if (v) begin
`ifdef FFT_WINDOW_EN
            ed = hann(d, m_idx);
`else
            ed = d;
`endif
            sq.push_back('{ed, logic'(m_idx == 0),
                           logic'(m_idx == NSAMPLES - 1), cyc + 3});
            m_idx = (m_idx + 1) % NSAMPLES;
        end else if (m_idx != 0) begin
            eq.push_back(cyc + 1);
            m_idx = 0;
        end
    endtask

    task automatic burst(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       step(1'b1, 1'b1, 16'sh7FFF);
                1:       step(1'b1, 1'b1, (i % 512 == 0) ? -16'sh8000 : vecs[i % 8]);
                default: step(1'b1, 1'b1, sample_t'($urandom));
            endcase
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        repeat (5) step(1'b0, 1'b1, sample_t'($urandom));
        step(1'b1, 1'b1, 16'sh1234);
        repeat (5) step(1'b1, 1'b0, '0);

        burst(NSAMPLES, 0);
        burst(NSAMPLES, 1);
        repeat (3) step(1'b1, 1'b0, '0);

        burst(2 * NSAMPLES, 2);

        burst(100, 2);
        step(1'b1, 1'b0, '0);
        burst(NSAMPLES, 2);

        burst(50, 2);
        repeat (2) step(1'b0, 1'b1, sample_t'($urandom));
        burst(NSAMPLES, 2);

        repeat (10) step(1'b1, 1'b0, '0);
        chk(sq.size() == 0, "drain_outputs", sq.size(), 0);
        chk(eq.size() == 0, "drain_frame_err", eq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
